exu_fpu_wb: RTL

- Writeback stage directly downstream of the FPU control block.
- Tracks the destination register of the in-flight FP op and captures its registered result and fflags one cycle after finish.
- Buffers completed results in a small FIFO until the FP register-file write port is granted.
- Exports a per-register busy bitmap for decode hazard checks and an issue stall.

---
 rtl/exu_fpu_wb.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/exu_fpu_wb.sv
`default_nettype none
// ============================================================================
// exu_fpu_wb : FP writeback stage - pending/capture tracking, result FIFO,
//              register busy bitmap and issue stall.   Rev 1.0
// ============================================================================
module exu_fpu_wb #(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_l,
  input  logic        scan_mode,
  input  logic        issue_valid,
  input  logic [4:0]  issue_rd,
  input  logic        flush_lower,
  input  logic        fpu_finish,
  input  logic [31:0] fpu_result,
  input  logic [4:0]  fpu_fflags,
  input  logic        wb_ready,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        fflags_wr_en,
  output logic [4:0]  fflags_wr_data,
  output logic        issue_stall,
  output logic [31:0] rd_busy
);
  localparam int AW = $clog2(DEPTH);

  logic          pend_vld_q, pend_vld_d;
  logic [4:0]    pend_rd_q, pend_rd_d;
  logic          cap_vld_q, cap_vld_d;
  logic [4:0]    cap_rd_q, cap_rd_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic [4:0]    mem_rd_q    [DEPTH];
  logic [4:0]    mem_rd_d    [DEPTH];
  logic [31:0]   mem_data_q  [DEPTH];
  logic [31:0]   mem_data_d  [DEPTH];
  logic [4:0]    mem_flags_q [DEPTH];
  logic [4:0]    mem_flags_d [DEPTH];

  logic          w_full, w_push, w_push_ok, w_pop;
  logic [AW+1:0] w_occ;
  logic [AW-1:0] w_off;
  logic [31:0]   w_rd_busy;
  logic          unused_scan;

  // Scan muxing lives in the flop cells themselves; nothing to do here.
  assign unused_scan = scan_mode;

  assign w_full    = (count_q == (AW+1)'(DEPTH));
  assign w_push    = cap_vld_q;
  assign w_pop     = wb_valid & wb_ready;
  assign w_push_ok = w_push & (~w_full | w_pop);

  always_comb begin
    pend_vld_d = pend_vld_q;
    pend_rd_d  = pend_rd_q;
    if (flush_lower) begin
      pend_vld_d = 1'b0;
    end else if (issue_valid) begin
      pend_vld_d = 1'b1;
      pend_rd_d  = issue_rd;
    end else if (fpu_finish) begin
      pend_vld_d = 1'b0;
    end
    cap_vld_d = fpu_finish & pend_vld_q & ~flush_lower;
    cap_rd_d  = pend_rd_q;
  end

  always_comb begin
    mem_rd_d    = mem_rd_q;
    mem_data_d  = mem_data_q;
    mem_flags_d = mem_flags_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    if (w_push_ok) begin
      mem_rd_d[wr_ptr_q]    = cap_rd_q;
      mem_data_d[wr_ptr_q]  = fpu_result;
      mem_flags_d[wr_ptr_q] = fpu_fflags;
      wr_ptr_d              = wr_ptr_q + 1'b1;
    end
    if (w_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    if (w_push_ok && !w_pop) begin
      count_d = count_q + 1'b1;
    end else if (!w_push_ok && w_pop) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      pend_vld_q <= 1'b0;
      pend_rd_q  <= '0;
      cap_vld_q  <= 1'b0;
      cap_rd_q   <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_rd_q[i]    <= '0;
        mem_data_q[i]  <= '0;
        mem_flags_q[i] <= '0;
      end
    end else begin
      pend_vld_q  <= pend_vld_d;
      pend_rd_q   <= pend_rd_d;
      cap_vld_q   <= cap_vld_d;
      cap_rd_q    <= cap_rd_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      mem_rd_q    <= mem_rd_d;
      mem_data_q  <= mem_data_d;
      mem_flags_q <= mem_flags_d;
    end
  end

  // Entry i is live when its distance from the head is below the count.
  always_comb begin
    w_rd_busy = '0;
    w_off     = '0;
    if (pend_vld_q) w_rd_busy[pend_rd_q] = 1'b1;
    if (cap_vld_q)  w_rd_busy[cap_rd_q]  = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      w_off = AW'(i) - rd_ptr_q;
      if ({1'b0, w_off} < count_q) w_rd_busy[mem_rd_q[i]] = 1'b1;
    end
  end

  assign w_occ = (AW+2)'(count_q) + (AW+2)'(cap_vld_q) + (AW+2)'(pend_vld_q)
               - (AW+2)'(w_pop);

  assign wb_valid       = (count_q != '0);
  assign wb_rd          = mem_rd_q[rd_ptr_q];
  assign wb_data        = mem_data_q[rd_ptr_q];
  assign fflags_wr_data = mem_flags_q[rd_ptr_q];
  assign fflags_wr_en   = w_pop;
  assign issue_stall    = (pend_vld_q & ~fpu_finish) | (w_occ >= (AW+2)'(DEPTH));
  assign rd_busy        = w_rd_busy;

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_l)
    !(w_push && w_full && !w_pop));

endmodule
`default_nettype wire
